// File: rtl/test_ctrl_pkg.sv
// Shared types for the test-control peripheral:
// sequencer states and register offsets.
package test_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT,
    RUN,
    DONE
  } state_t;

  localparam logic [4:0] OFF_TOHOST  = 5'h00;
  localparam logic [4:0] OFF_TIMEOUT = 5'h04;
  localparam logic [4:0] OFF_CYC_LO  = 5'h08;
  localparam logic [4:0] OFF_CYC_HI  = 5'h0C;
  localparam logic [4:0] OFF_SCRATCH = 5'h10;

  function automatic logic released(state_t s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/test_ctrl_if.sv
// Core-side request/response bus of the
// test-control register file.
interface test_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/test_ctrl_rst_seq.sv
// Core reset sequencer: waits for calibration,
// holds reset RST_HOLD cycles, then releases.
module test_ctrl_rst_seq
  import test_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   calib_done,
  input  logic   stop,
  output state_t state,
  output logic   core_reset_n
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] LAST = HW'(RST_HOLD - 1);

  state_t          state_n;
  logic [HW-1:0]   cnt;
  logic [HW-1:0]   cnt_n;
  logic            core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLD;
      cnt          <= '0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      core_reset_n <= core_n;
    end
  end

  // Losing calibration mid-hold restarts the whole hold.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      HOLD: begin
        if (calib_done) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (!calib_done) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (stop) state_n = DONE;
      end
      DONE: state_n = DONE;
      default: state_n = HOLD;
    endcase
    core_n = released(state_n);
  end

endmodule

// File: rtl/test_ctrl.sv
// Test-control peripheral: tohost/timeout/cycle
// registers, watchdog and sticky stop status.
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h4000_0000),
  parameter int                RST_HOLD    = 16,
  parameter int                TIMEOUT_W   = 32,
  parameter int unsigned       DEF_TIMEOUT = 1_000_000,
  parameter int                CYC_W       = 64
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        calib_done,
  output logic        core_reset_n,
  test_ctrl_if.slave  bus,
  output logic        test_stop,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [30:0] test_code
);

  localparam int TW   = TIMEOUT_W;
  localparam int HI_W = CYC_W - 32;

  state_t          state;
  logic            running;
  logic            xfer;
  logic            hit;
  logic [4:0]      off;
  logic            wr;
  logic            rd;
  logic            wr_tohost;
  logic            wr_tmo;
  logic            wr_scr;
  logic            rd_lo;
  logic            done_wr;
  logic            expire;
  logic            stop_set;
  logic            sel_th;
  logic            sel_tmo;
  logic            sel_lo;
  logic            sel_hi;
  logic            sel_scr;
  logic [31:0]     rdata;
  logic [31:0]     tohost;
  logic [31:0]     scratch;
  logic [TW-1:0]   timeout;
  logic [TW-1:0]   wd_cnt;
  logic [TW-1:0]   wd_inc;
  logic [CYC_W-1:0] cyc;
  logic [HI_W-1:0] shadow;

  test_ctrl_rst_seq #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_seq (
    .clk          (clk_core),
    .rst_n        (reset_n),
    .calib_done   (calib_done),
    .stop         (stop_set),
    .state        (state),
    .core_reset_n (core_reset_n)
  );

  assign running       = (state == RUN);
  assign bus.req_ready = released(state);
  assign xfer          = bus.req_valid && bus.req_ready;
  assign off           = bus.req_addr[4:0];

  // Misaligned or out-of-window accesses fall through as unmapped.
  assign hit = (bus.req_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5])
            && (off[1:0] == 2'b00);

  assign wr        = xfer && bus.req_we && hit;
  assign rd        = xfer && !bus.req_we && hit;
  assign wr_tohost = wr && (off == OFF_TOHOST) && running;
  assign wr_tmo    = wr && (off == OFF_TIMEOUT) && running;
  assign wr_scr    = wr && (off == OFF_SCRATCH);
  assign rd_lo     = rd && (off == OFF_CYC_LO);
  assign done_wr   = wr_tohost && bus.req_wdata[0];

  // A TIMEOUT write restarts the count, so it cannot expire that cycle.
  assign wd_inc   = wd_cnt + 1'b1;
  assign expire   = running && !wr_tmo
                 && (timeout != '0) && (wd_inc == timeout);
  assign stop_set = done_wr || expire;

  assign sel_th  = rd && (off == OFF_TOHOST);
  assign sel_tmo = rd && (off == OFF_TIMEOUT);
  assign sel_lo  = rd_lo;
  assign sel_hi  = rd && (off == OFF_CYC_HI);
  assign sel_scr = rd && (off == OFF_SCRATCH);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_th:  rdata = tohost;
      sel_tmo: rdata = 32'(timeout);
      sel_lo:  rdata = cyc[31:0];
      sel_hi:  rdata = 32'(shadow);
      sel_scr: rdata = scratch;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= xfer;
      bus.resp_rdata <= rdata;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      tohost  <= '0;
      timeout <= TW'(DEF_TIMEOUT);
      scratch <= '0;
      shadow  <= '0;
    end else begin
      if (wr_tohost) tohost  <= bus.req_wdata;
      if (wr_tmo)    timeout <= TW'(bus.req_wdata);
      if (wr_scr)    scratch <= bus.req_wdata;
      if (rd_lo)     shadow  <= cyc[CYC_W-1:32];
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      cyc    <= '0;
      wd_cnt <= '0;
    end else if (running) begin
      cyc    <= cyc + 1'b1;
      wd_cnt <= wr_tmo ? '0 : wd_inc;
    end
  end

  // The tohost write wins over a same-cycle watchdog expiry.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      test_stop    <= 1'b0;
      test_pass    <= 1'b0;
      test_timeout <= 1'b0;
      test_code    <= '0;
    end else if (done_wr) begin
      test_stop    <= 1'b1;
      test_pass    <= (bus.req_wdata[31:1] == 31'd0);
      test_timeout <= 1'b0;
      test_code    <= bus.req_wdata[31:1];
    end else if (expire) begin
      test_stop    <= 1'b1;
      test_pass    <= 1'b0;
      test_timeout <= 1'b1;
      test_code    <= '0;
    end
  end

endmodule

// File: tb/tb_test_ctrl.sv
// Randomized scoreboard bench for test_ctrl with
// a cycle-level behavioural reference model.
module tb_test_ctrl;

  localparam int          RST_HOLD = 16;
  localparam int unsigned DEF_TMO  = 20000;
  localparam logic [31:0] BASE     = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done;
  logic        core_reset_n;
  logic        test_stop;
  logic        test_pass;
  logic        test_timeout;
  logic [30:0] test_code;

  test_ctrl_if #(.ADDR_W(32)) bus ();

  test_ctrl #(
    .ADDR_W      (32),
    .BASE_ADDR   (BASE),
    .RST_HOLD    (RST_HOLD),
    .TIMEOUT_W   (32),
    .DEF_TIMEOUT (DEF_TMO),
    .CYC_W       (64)
  ) dut (
    .clk_core     (clk),
    .reset_n      (reset_n),
    .calib_done   (calib_done),
    .core_reset_n (core_reset_n),
    .bus          (bus),
    .test_stop    (test_stop),
    .test_pass    (test_pass),
    .test_timeout (test_timeout),
    .test_code    (test_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int  checks = 0;
  int  errors = 0;
  int  cyc;
  bit  chk_en = 1'b0;

  bit               m_run;
  bit               m_done;
  int               m_rel_cyc;
  longint unsigned  m_cycles;
  longint unsigned  m_wd;
  logic [31:0]      m_tohost;
  logic [31:0]      m_timeout;
  logic [31:0]      m_scratch;
  logic [31:0]      m_shadow;
  bit               m_stop;
  bit               m_pass;
  bit               m_tmo;
  logic [30:0]      m_code;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cyc       = 0;
    m_run     = 0;
    m_done    = 0;
    m_rel_cyc = 32'h7fff_ffff;
    m_cycles  = 0;
    m_wd      = 0;
    m_tohost  = 0;
    m_timeout = DEF_TMO;
    m_scratch = 0;
    m_shadow  = 0;
    m_stop    = 0;
    m_pass    = 0;
    m_tmo     = 0;
    m_code    = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference model, using pre-edge state.
  task automatic step();
    bit          xfer;
    bit          hit;
    bit          tmo_wr;
    bit          th_done;
    bit          expire;
    logic [4:0]  off;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rv;
    cyc++;
    a       = bus.req_addr;
    d       = bus.req_wdata;
    off     = a[4:0];
    xfer    = bus.req_valid && m_run;
    hit     = (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
    tmo_wr  = xfer && bus.req_we && hit && off == 5'h04 && !m_done;
    th_done = xfer && bus.req_we && hit && off == 5'h00
           && d[0] && !m_done;
    expire  = 0;
    if (xfer) begin
      rv = 0;
      if (!bus.req_we && hit) begin
        case (off)
          5'h00:   rv = m_tohost;
          5'h04:   rv = m_timeout;
          5'h08:   rv = m_cycles[31:0];
          5'h0C:   rv = m_shadow;
          5'h10:   rv = m_scratch;
          default: rv = 0;
        endcase
        if (off == 5'h08) m_shadow = m_cycles[63:32];
      end
      exp_q.push_back('{rd: rv, cyc: cyc});
      if (bus.req_we && hit && !m_done) begin
        if (off == 5'h00) m_tohost  = d;
        if (off == 5'h04) m_timeout = d;
      end
      if (bus.req_we && hit && off == 5'h10) m_scratch = d;
    end
    if (m_run && !m_done) begin
      m_cycles++;
      if (tmo_wr) m_wd = 0;
      else begin
        m_wd++;
        expire = (m_timeout != 0) && (m_wd == longint'(m_timeout));
      end
      if (th_done) begin
        m_stop = 1; m_done = 1; m_tmo = 0;
        m_code = d[31:1];
        m_pass = (d[31:1] == 0);
      end else if (expire) begin
        m_stop = 1; m_done = 1; m_tmo = 1;
        m_pass = 0; m_code = 0;
      end
    end
    if (cyc == m_rel_cyc) m_run = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  task automatic issue(bit we, logic [31:0] a, logic [31:0] d);
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    tick();
    chk_en = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ctl", {core_reset_n, bus.req_ready, bus.resp_valid,
                    test_stop, test_pass, test_timeout}, 0);
    chk("rst_code", test_code, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    bus.req_valid = 1'b0;
    calib_done    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    chk_en  = 1;
  endtask

  task automatic wait_release();
    int n;
    bit early;
    n = 0;
    early = 0;
    while (!core_reset_n && n < 500) begin
      if (bus.req_ready) early = 1;
      tick();
      n++;
    end
    chk("release_seen", core_reset_n, 1);
    chk("release_cycle", cyc, m_rel_cyc);
    chk("ready_before_release", early, 0);
  endtask

  task automatic seq_basic(int c);
    m_rel_cyc = c + RST_HOLD + 1;
    while (cyc < c) tick();
    calib_done = 1'b1;
    wait_release();
  endtask

  // Calibration drops for one cycle part-way through the hold.
  task automatic seq_drop(int c);
    m_rel_cyc = c + 6 + RST_HOLD + 1;
    while (cyc < c) tick();
    calib_done = 1'b1;
    while (cyc < c + 5) tick();
    calib_done = 1'b0;
    tick();
    calib_done = 1'b1;
    wait_release();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("status",
          {core_reset_n, bus.req_ready, test_stop,
           test_pass, test_timeout, test_code},
          {m_run, m_run, m_stop, m_pass, m_tmo, m_code});
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got resp_valid=1 expected 0 (cycle %0d)",
                   cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rd);
          chk("resp_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missing: got resp_valid=0 expected 1 (cycle %0d)",
                 cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int          n;
    int unsigned sel;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    reset_n       = 1'b0;
    calib_done    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_clear();
    #50;
    chk("init_ctl", {core_reset_n, bus.req_ready, bus.resp_valid,
                     test_stop, test_pass, test_timeout}, 0);
    chk("init_code", test_code, 0);
    #50;
    reset_n = 1'b1;
    chk_en  = 1;

    seq_basic(50);
    issue(0, BASE + 32'h00, 0);
    issue(0, BASE + 32'h04, 0);
    issue(0, BASE + 32'h10, 0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      we  = 1'($urandom_range(0, 1));
      if (sel < 8) a = BASE + 32'(sel * 4);
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 31));
      else a = BASE ^ (32'h1 << $urandom_range(5, 31));
      d = $urandom;
      if (we && a == BASE) d[0] = 1'b0;
      if (we && a == BASE + 32'h04) begin
        if ($urandom_range(0, 7) == 0) d = 0;
        else d = $urandom_range(2000, 60000);
      end
      issue(we, a, d);
      repeat ($urandom_range(0, 2)) tick();
    end

    issue(0, BASE + 32'h08, 0);
    issue(0, BASE + 32'h0C, 0);
    issue(0, BASE + 32'h18, 0);

    issue(1, BASE, 32'h1);
    chk("pass_flags", {test_stop, test_pass, test_timeout}, 3'b110);
    chk("pass_code", test_code, 0);
    issue(1, BASE, 32'h7);
    issue(0, BASE, 0);
    issue(1, BASE + 32'h04, 5);
    issue(0, BASE + 32'h04, 0);
    issue(1, BASE + 32'h10, 32'hA5A5_0F0F);
    issue(0, BASE + 32'h10, 0);
    issue(0, BASE + 32'h08, 0);
    tick();
    issue(0, BASE + 32'h08, 0);
    tick();
    chk("pass_sticky", {test_stop, test_pass, test_timeout}, 3'b110);

    do_reset();
    seq_drop(20);
    issue(1, BASE, 32'h0000_0007);
    chk("fail_flags", {test_stop, test_pass, test_timeout}, 3'b100);
    chk("fail_code", test_code, 3);

    do_reset();
    seq_basic(10);
    repeat (5) tick();
    issue(0, BASE + 32'h08, 0);
    issue(0, BASE + 32'h0C, 0);
    issue(1, BASE + 32'h04, 100);
    n = 0;
    while (!test_timeout && n < 300) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 100);
    chk("wd_flags", {test_stop, test_pass, test_timeout}, 3'b101);
    chk("wd_code", test_code, 0);

    do_reset();
    seq_basic(10);
    issue(1, BASE + 32'h04, 50);
    repeat (49) tick();
    issue(1, BASE, 32'h1);
    chk("race_flags", {test_stop, test_pass, test_timeout}, 3'b110);

    tick();
    tick();
    tick();
    chk("resp_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_ctrl.md
Name: test_ctrl

Overview:
- Synthesizable, parametrised test-control peripheral: replaces the hard-wired test-stop probe used by the system-level bench.
- Sequences core reset: held after reset_n release until DDR3 calibration completes and a configurable hold count elapses.
- Exposes a memory-mapped tohost/timeout/cycle-counter register file to the core; drives sticky stop/pass/timeout outputs the bench waits on.
- Sits in top, beside the core's data bus and the MIG calibration flag.

Parameters:
- ADDR_W, 32, request address width.
- BASE_ADDR, 32'h4000_0000, register-file base; only bits [ADDR_W-1:5] are decoded.
- RST_HOLD, 16, core-reset hold cycles after calibration (>=1).
- TIMEOUT_W, 32, watchdog counter width.
- DEF_TIMEOUT, 1_000_000, watchdog reset value in cycles; 0 disables the watchdog.
- CYC_W, 64, cycle counter width (33..64).

Ports:
- clk_core  in  1  single clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- calib_done  in  1  MIG init_calib_complete; synchronous to clk_core.
- core_reset_n  out  1  sequenced core reset, active-low.
- req_valid  in  1  bus request.
- req_ready  out  1  block accepts the request.
- req_we  in  1  1 = write.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  read data; 0 for writes and unmapped addresses.
- test_stop  out  1  sticky: test finished (tohost write or timeout).
- test_pass  out  1  sticky: finished with code 0, no timeout.
- test_timeout  out  1  sticky: watchdog expired.
- test_code  out  31  tohost[31:1] latched at stop.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; state HOLD; hold counter 0; timeout register = DEF_TIMEOUT; cycle counter 0.
- State machine:
  - HOLD: waits for calib_done=1, then goes to WAIT.
  - WAIT: counts RST_HOLD cycles, then goes to RUN.
  - RUN: core_reset_n=1 in the first RUN cycle, registered.
  - DONE: entered from RUN when test_stop sets.
- calib_done dropping in WAIT returns the FSM to HOLD and clears the count. In RUN or DONE, calib_done changes are ignored.
- Cycle counter increments every RUN cycle; it freezes in DONE and wraps at 2^CYC_W.
- Watchdog:
  - Counts RUN cycles; on reaching TIMEOUT (nonzero) -> test_timeout=1, test_stop=1, test_pass=0, test_code=0, state DONE.
  - Writing TIMEOUT restarts the watchdog count from 0.
- Bus handshake:
  - req_ready=1 in every state except HOLD and WAIT.
  - A transfer occurs when req_valid && req_ready.
  - resp_valid is asserted exactly one cycle later; one outstanding request at most, no back-pressure on the response.
- Register map (offset = req_addr[4:0]; accesses that are not word-aligned are treated as unmapped):
  - 0x00 TOHOST, RW. Write with bit0=1 and state RUN -> test_stop=1, test_code=wdata[31:1], test_pass=(wdata[31:1]==0), state DONE. Write with bit0=0 only stores the value. Read returns the last written value.
  - 0x04 TIMEOUT, RW, width TIMEOUT_W; zero-extended or truncated to 32 bits.
  - 0x08 CYCLE_LO, RO. Reading latches CYCLE[CYC_W-1:32] into a shadow register for a coherent high read.
  - 0x0C CYCLE_HI, RO, returns the shadow value.
  - 0x10 SCRATCH, RW, 32 bits.
  - Other offsets: reads return 0, writes are ignored, and the response is still generated.
- In DONE:
  - Writes to TOHOST and TIMEOUT are ignored.
  - Reads are still served.
  - Sticky outputs hold until reset_n.
- Same-cycle watchdog expiry and TOHOST done-write: the TOHOST write wins (pass/code from the write, test_timeout=0).
- Address outside the BASE_ADDR window: treated as unmapped.
- Reset mid-operation: all state is restored to reset values immediately.

Decomposition:
- Package test_ctrl_pkg holds:
  - state enum (HOLD, WAIT, RUN, DONE);
  - register offset constants (OFF_TOHOST, OFF_TIMEOUT, OFF_CYC_LO, OFF_CYC_HI, OFF_SCRATCH).
- One sub-module is natural: rst_seq (HOLD/WAIT/RUN sequencing, hold counter, core_reset_n). test_ctrl holds the register file, watchdog and stop logic.

Test Plan:
- Calibration gating: reset_n high at 100 ns, calib_done rising at cycle 50 -> core_reset_n rises at cycle 50+RST_HOLD+1 (67); req_ready=0 before that.
- Calibration drop in WAIT: calib_done pulses low at WAIT cycle 5 -> hold restarts; core_reset_n rises RST_HOLD+1 cycles after calib_done returns.
- Passing test: write TOHOST=32'h1 -> next cycle test_stop=1, test_pass=1, test_code=0; subsequent TOHOST write 32'h7 is ignored.
- Failing test: write TOHOST=32'h0000_0007 -> test_code=3, test_pass=0, test_timeout=0.
- Watchdog expiry: TIMEOUT=100, no tohost write -> test_timeout=test_stop=1 exactly 100 RUN cycles after the write. Same cycle expiry plus TOHOST=1 -> test_pass=1, test_timeout=0.
- Cycle counter:
  - read CYCLE_LO, then CYCLE_HI -> the 64-bit value equals the RUN cycle count at the LO read;
  - unmapped offset 0x18 -> resp_rdata=0;
  - resp_valid is exactly one cycle after each transfer.
